l293d_pwm_driver: RTL



---
 rtl/l293d_pwm_driver.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/l293d_pwm_driver.sv
// Multi-channel L293D H-bridge driver: shared PWM timebase,
// per-channel on/direction FSM with dead-time interlock on reversal.
module l293d_pwm_driver #(
    parameter int NUM_MOTORS      = 2,
    parameter int DUTY_W          = 8,
    parameter int PWM_PRESCALE    = 1,
    parameter int DEADTIME_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_MOTORS-1:0]        motor_on,
    input  logic [NUM_MOTORS-1:0]        motor_dir,
    input  logic [NUM_MOTORS*DUTY_W-1:0] motor_duty,
    output logic [NUM_MOTORS-1:0]        enable,
    output logic [NUM_MOTORS-1:0]        input_fwd,
    output logic [NUM_MOTORS-1:0]        input_bwd,
    output logic [NUM_MOTORS-1:0]        reversing
);

    localparam int PS_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam int DC_W = (DEADTIME_CYCLES > 0) ? $clog2(DEADTIME_CYCLES + 1) : 1;

    localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PWM_PRESCALE - 1);
    localparam logic [DUTY_W-1:0] CNT_LAST = {{(DUTY_W-1){1'b1}}, 1'b0};
    localparam logic [DC_W-1:0]   DC_LOAD  =
        DC_W'((DEADTIME_CYCLES > 0) ? DEADTIME_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DEAD  = 2'd2
    } state_e;

    logic [PS_W-1:0]   pre_q, pre_d;
    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic              tick, wrap;

    state_e            st_q   [NUM_MOTORS];
    state_e            st_d   [NUM_MOTORS];
    logic              dir_q  [NUM_MOTORS];
    logic              dir_d  [NUM_MOTORS];
    logic [DC_W-1:0]   dc_q   [NUM_MOTORS];
    logic [DC_W-1:0]   dc_d   [NUM_MOTORS];
    logic [DUTY_W-1:0] duty_q [NUM_MOTORS];
    logic [DUTY_W-1:0] duty_d [NUM_MOTORS];

    logic [NUM_MOTORS-1:0] pwm_hi;
    logic [NUM_MOTORS-1:0] en_q, en_d;
    logic [NUM_MOTORS-1:0] fwd_q, fwd_d;
    logic [NUM_MOTORS-1:0] bwd_q, bwd_d;
    logic [NUM_MOTORS-1:0] rev_q, rev_d;

    // Shared timebase: prescaler tick and PWM counter with wrap at 2^W-2.
    always_comb begin
        tick  = (pre_q == PS_LAST);
        wrap  = tick && (cnt_q == CNT_LAST);
        pre_d = tick ? '0 : pre_q + 1'b1;
        cnt_d = cnt_q;
        if (tick) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Per-channel next state; pins decode from the next state so they
    // change on the same edge as the FSM.
    always_comb begin
        for (int i = 0; i < NUM_MOTORS; i++) begin
            duty_d[i] = wrap ? motor_duty[i*DUTY_W +: DUTY_W] : duty_q[i];
            pwm_hi[i] = (cnt_q < duty_q[i]);
            st_d[i]   = st_q[i];
            dir_d[i]  = dir_q[i];
            dc_d[i]   = dc_q[i];
            unique case (st_q[i])
                IDLE: begin
                    if (motor_on[i]) begin
                        st_d[i]  = DRIVE;
                        dir_d[i] = motor_dir[i];
                    end
                end
                DRIVE: begin
                    if (!motor_on[i]) begin
                        st_d[i] = IDLE;
                    end else if (motor_dir[i] != dir_q[i]) begin
                        if (DEADTIME_CYCLES > 0) begin
                            st_d[i] = DEAD;
                            dc_d[i] = DC_LOAD;
                        end else begin
                            dir_d[i] = motor_dir[i];
                        end
                    end
                end
                DEAD: begin
                    if (!motor_on[i]) begin
                        st_d[i] = IDLE;
                    end else if (dc_q[i] == '0) begin
                        st_d[i]  = DRIVE;
                        dir_d[i] = motor_dir[i];
                    end else begin
                        dc_d[i] = dc_q[i] - 1'b1;
                    end
                end
                default: st_d[i] = IDLE;
            endcase
            en_d[i]  = (st_d[i] == DRIVE) && pwm_hi[i];
            fwd_d[i] = (st_d[i] == DRIVE) && dir_d[i];
            bwd_d[i] = (st_d[i] == DRIVE) && !dir_d[i];
            rev_d[i] = (st_d[i] == DEAD);
        end
    end

    // Timebase registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

    // Channel state, latched duty and registered pin outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                st_q[i]   <= IDLE;
                dir_q[i]  <= 1'b0;
                dc_q[i]   <= '0;
                duty_q[i] <= '0;
            end
            en_q  <= '0;
            fwd_q <= '0;
            bwd_q <= '0;
            rev_q <= '0;
        end else begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                st_q[i]   <= st_d[i];
                dir_q[i]  <= dir_d[i];
                dc_q[i]   <= dc_d[i];
                duty_q[i] <= duty_d[i];
            end
            en_q  <= en_d;
            fwd_q <= fwd_d;
            bwd_q <= bwd_d;
            rev_q <= rev_d;
        end
    end

    assign enable    = en_q;
    assign input_fwd = fwd_q;
    assign input_bwd = bwd_q;
    assign reversing = rev_q;

endmodule
